// File: rtl/seq_fsm_pkg.sv
// Shared types and constants for the seq_fsm sequencer.
package seq_fsm_pkg;

    localparam int SEQ_W = 4;

    typedef enum logic [SEQ_W-1:0] {
        S0  = 4'd0,
        S1  = 4'd1,
        S2  = 4'd2,
        S3  = 4'd3,
        S4  = 4'd4,
        S5  = 4'd5,
        S6  = 4'd6,
        S7  = 4'd7,
        S8  = 4'd8,
        S9  = 4'd9,
        S10 = 4'd10,
        S11 = 4'd11,
        S12 = 4'd12,
        S13 = 4'd13,
        S14 = 4'd14,
        S15 = 4'd15
    } state_t;

    localparam state_t FIRST_STATE = S0;
    localparam state_t LAST_STATE  = S15;

endpackage

// File: rtl/seq_fsm_if.sv
// Control/status bundle between a sequence consumer and seq_fsm.
// The tc signal exists only when SEQ_FSM_TC_EN is defined.
interface seq_fsm_if;
    import seq_fsm_pkg::*;

    logic             ce;
    logic             load;
    logic             up;
    logic [SEQ_W-1:0] data;
    logic [SEQ_W-1:0] seq;
`ifdef SEQ_FSM_TC_EN
    logic             tc;

    modport master (output ce, load, up, data, input seq, tc);
    modport slave  (input ce, load, up, data, output seq, tc);
`else
    modport master (output ce, load, up, data, input seq);
    modport slave  (input ce, load, up, data, output seq);
`endif

endinterface

// File: rtl/seq_fsm.sv
// 16-state up/down sequencer with synchronous load; seq is the state index.
// Optional terminal-count output enabled by defining SEQ_FSM_TC_EN.
module seq_fsm
    import seq_fsm_pkg::*;
#(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic      clk,
    input  logic      rst,
    seq_fsm_if.slave  bus
);

    localparam state_t RST_ST = state_t'(RST_STATE);

    state_t state;

    function automatic state_t succ_fwd(input state_t s);
        state_t n;
        case (s)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S3;
            S3:      n = S4;
            S4:      n = S5;
            S5:      n = S6;
            S6:      n = S7;
            S7:      n = S8;
            S8:      n = S9;
            S9:      n = S10;
            S10:     n = S11;
            S11:     n = S12;
            S12:     n = S13;
            S13:     n = S14;
            S14:     n = S15;
            S15:     n = S0;
            default: n = FIRST_STATE;
        endcase
        return n;
    endfunction

    function automatic state_t succ_bwd(input state_t s);
        state_t n;
        case (s)
            S0:      n = S15;
            S1:      n = S0;
            S2:      n = S1;
            S3:      n = S2;
            S4:      n = S3;
            S5:      n = S4;
            S6:      n = S5;
            S7:      n = S6;
            S8:      n = S7;
            S9:      n = S8;
            S10:     n = S9;
            S11:     n = S10;
            S12:     n = S11;
            S13:     n = S12;
            S14:     n = S13;
            S15:     n = S14;
            default: n = LAST_STATE;
        endcase
        return n;
    endfunction

    // Priority: reset, then load (ignores ce/up), then enabled step, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_ST;
        end else if (bus.load) begin
            state <= state_t'(bus.data);
        end else if (bus.ce) begin
            state <= bus.up ? succ_fwd(state) : succ_bwd(state);
        end
    end

    assign bus.seq = state;

`ifdef SEQ_FSM_TC_EN
    // High when the coming edge wraps; forced low while reset is asserted.
    assign bus.tc = ~rst & bus.ce & ~bus.load &
                    ((bus.up & (state == LAST_STATE)) | (~bus.up & (state == FIRST_STATE)));
`endif

endmodule

// File: tb/tb_seq_fsm.sv
// Self-checking bench for seq_fsm: directed plan plus randomized traffic vs. a modulo-16 model.
module tb_seq_fsm;
    import seq_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst;

    seq_fsm_if bus ();

    seq_fsm #(.RST_STATE(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model    = 0;
    bit model_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic on the state index with the stated priority order.
    always @(posedge clk) begin
        if (rst) begin
            model       <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (bus.load)
                model <= int'(bus.data);
            else if (bus.ce)
                model <= bus.up ? (model + 1) % 16 : (model + 15) % 16;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("seq", int'(bus.seq), model);
`ifdef SEQ_FSM_TC_EN
            check("tc", int'(bus.tc),
                  int'(!rst && bus.ce && !bus.load &&
                       ((bus.up && model == 15) || (!bus.up && model == 0))));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        bus.ce   = 1'b0;
        bus.load = 1'b0;
        bus.up   = 1'b0;
        bus.data = '0;

        step(10);
        check("reset_seq", int'(bus.seq), 0);
        rst = 1'b0;
        step(1);
        check("after_release", int'(bus.seq), 0);

        bus.ce = 1'b1;
        bus.up = 1'b1;
        step(17);
        check("count_up_wrap", int'(bus.seq), 1);

        bus.up = 1'b0;
        step(18);
        check("count_down_wrap", int'(bus.seq), 15);

        bus.ce = 1'b0;
        step(10);
        check("hold", int'(bus.seq), 15);

        bus.load = 1'b1;
        for (int d = 0; d < 16; d++) begin
            bus.data = 4'(d);
            step(2);
            check("load_step", int'(bus.seq), d);
        end

        bus.data = 4'd9;
        step(1);
        check("load_nine", int'(bus.seq), 9);
        bus.ce   = 1'b1;
        bus.up   = 1'b1;
        bus.data = 4'd5;
        step(1);
        check("load_beats_count", int'(bus.seq), 5);
        bus.load = 1'b0;
        step(3);
        check("count_after_load", int'(bus.seq), 8);
        rst = 1'b1;
        step(1);
        check("reset_mid_count", int'(bus.seq), 0);
        rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            bus.load = ($urandom_range(0, 7) == 0);
            bus.ce   = ($urandom_range(0, 3) != 0);
            bus.up   = 1'($urandom_range(0, 1));
            bus.data = 4'($urandom_range(0, 15));
            step(1);
        end

        rst      = 1'b0;
        bus.load = 1'b0;
        bus.ce   = 1'b0;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_fsm.md
Name: seq_fsm

Overview:
- 16-state synchronous sequencer. The 4-bit output `seq` is the binary index of the current state.
- Steps forward or backward through S0..S15 with wrap-around when `ce` is asserted.
- Holds its state when `ce` is deasserted.
- Can be loaded directly with any state via `load`/`data`.
- Used as a controllable sequence/count source for downstream datapath logic.

Parameters:
- RST_STATE, 4'd0: state index entered on reset. Legal values 0..15.

Ports:
- clk   input   1   system clock; all state changes on rising edge.
- rst   input   1   synchronous, active-high reset.
- ce    input   1   count enable; step the sequence when high.
- load  input   1   synchronous load of `data` into state; works regardless of `ce`.
- up    input   1   direction: 1 = forward (S(n)->S(n+1)), 0 = backward (S(n)->S(n-1)).
- data  input   4   state index to load.
- seq   output  4   current state index (S0=0 .. S15=15).
- tc    output  1   terminal count; present only when SEQ_FSM_TC_EN is defined.

Behaviour:
- The state register holds one of 16 enumerated states S0..S15. Encoding is binary, equal to the index.
- `seq` is driven directly from the state register. It changes only after a rising clk edge, never combinationally from inputs.
- Priority on each rising edge, highest first:
  1. `rst`=1: state <= RST_STATE; `seq` reads RST_STATE the cycle after the edge. Reset mid-count or mid-load overrides everything.
  2. `load`=1: state <= `data`, independent of `ce` and `up`.
  3. `ce`=1 and `up`=1: state <= S((n+1) mod 16); S15 wraps to S0.
  4. `ce`=1 and `up`=0: state <= S((n-1) mod 16); S0 wraps to S15.
  5. `ce`=0: hold.
- Latency is one clock from sampled inputs to updated `seq`.
- Changing `up` mid-run takes effect on the next enabled edge, with no skipped or repeated state.
- If `load` and `ce` are both high, the load wins and no increment is applied that cycle.
- Inputs X/Z are not handled. All inputs must be driven once reset is released.
- Initial (pre-reset) state is unspecified. A reset must be applied first.

Optional Feature:
- Macro: SEQ_FSM_TC_EN.
- Defined: the module adds output `tc` (1 bit), combinational from registered state and inputs.
  - `tc` = `ce` & ~`load` & ((`up` & state==S15) | (~`up` & state==S0)).
  - It flags that the next edge wraps. It is 0 during reset.
- Undefined: the `tc` port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package seq_fsm_pkg contains:
  - typedef enum logic [3:0] state_t {S0..S15};
  - localparam SEQ_W = 4;
  - localparam state_t FIRST_STATE = S0, LAST_STATE = S15.
- Next-state logic is an explicit case over state_t with forward and backward successors per state.
- No sub-module; a single module is natural.

Test Plan:
- rst=1 for 10 cycles, ce=0 -> seq=0 throughout and after release. With SEQ_FSM_TC_EN, tc=0.
- rst=0, ce=1, up=1 for 17 cycles from 0 -> seq 1,2,..,15,0,1 (wrap 15->0).
  - tc=1 only in the cycle where seq=15.
- Then up=0, ce=1 for 18 cycles -> seq counts down through 0 and wraps to 15, then continues 14, 13...
- ce=0, up=0, load=0 for 10 cycles -> seq holds its last value unchanged.
- ce=0, load=1, data stepped 0x0..0xF every 2 cycles -> seq equals data one edge after each change (0,1,..,F).
- load=1, ce=1, up=1, data=5 while seq=9 -> next seq=5 (load beats count).
  - Then assert rst mid-count -> seq=0 next edge.
